// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: produces the duty_cycle/period pair for a downstream PWM core.
// It repeats a trapezoidal brightness profile: ramp up, hold high, ramp down, hold low.
// Duty changes only at PWM period boundaries, so the core never sees a mid-period change.
// Fade limits are sampled once per fade cycle: on leaving IDLE and on leaving HOLD_LOW.
module pwm_fade_sequencer #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned PWM_FREQ = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] min_duty,
  input  logic [15:0] max_duty,
  input  logic [15:0] step,
  input  logic [15:0] hold_cycles,
  output logic [15:0] duty_cycle,
  output logic [15:0] period,
  output logic        update_tick,
  output logic [2:0]  state,
  output logic        cycle_done
);

  // PWM period in clocks; must lie in 2..65535 so it fits the 16-bit datapath.
  localparam int unsigned PERIOD   = CLK_FREQ / PWM_FREQ;
  localparam logic [15:0] PeriodW  = 16'(PERIOD);
  localparam logic [15:0] LastPcnt = 16'(PERIOD - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRampUp   = 3'd1;
  localparam logic [2:0] StHoldHigh = 3'd2;
  localparam logic [2:0] StRampDown = 3'd3;
  localparam logic [2:0] StHoldLow  = 3'd4;

  logic [15:0] pcnt_q, pcnt_d;
  logic        tick_q, tick_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] duty_q, duty_d;
  logic [15:0] hold_q, hold_d;
  logic        done_q, done_d;

  // Latched fade configuration for the current fade cycle.
  logic [15:0] max_eff_q, max_eff_d;
  logic [15:0] min_eff_q, min_eff_d;
  logic [15:0] step_eff_q, step_eff_d;
  logic [15:0] hold_eff_q, hold_eff_d;

  // Configuration as it would be latched if sampled this clock.
  logic [15:0] cfg_max;
  logic [15:0] cfg_min;
  logic [15:0] cfg_step;
  logic        sample;

  // 17-bit ramp arithmetic so duty+step can never wrap.
  logic [16:0] sum_up;
  logic [16:0] floor_dn;
  logic        up_hit;
  logic        dn_hit;
  logic        running;

  // Clamp the live limit inputs into a consistent configuration.
  always_comb begin
    cfg_max  = (max_duty < PeriodW) ? max_duty : PeriodW;
    cfg_min  = (min_duty < cfg_max) ? min_duty : cfg_max;
    cfg_step = (step == 16'd0) ? 16'd1 : step;
  end

  // Saturation decisions for the two ramps.
  always_comb begin
    sum_up   = {1'b0, duty_q} + {1'b0, step_eff_q};
    floor_dn = {1'b0, min_eff_q} + {1'b0, step_eff_q};
    up_hit   = (sum_up >= {1'b0, max_eff_q});
    dn_hit   = ({1'b0, duty_q} <= floor_dn);
  end

  // Period counter runs only while a fade is active; update_tick marks its last clock.
  always_comb begin
    running = enable && (state_q != StIdle);
    if (!running) begin
      pcnt_d = 16'd0;
    end else if (pcnt_q == LastPcnt) begin
      pcnt_d = 16'd0;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end
    tick_d = (pcnt_d == LastPcnt);
  end

  // Fade FSM next-state: all transitions except leaving IDLE wait for update_tick.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    sample     = 1'b0;
    max_eff_d  = max_eff_q;
    min_eff_d  = min_eff_q;
    step_eff_d = step_eff_q;
    hold_eff_d = hold_eff_q;

    if (!enable) begin
      // Dropping enable wins over any tick and aborts without cycle_done.
      state_d = StIdle;
      duty_d  = 16'd0;
      hold_d  = 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sample  = 1'b1;
          duty_d  = cfg_min;
          state_d = StRampUp;
        end
        StRampUp: begin
          if (tick_q) begin
            if (up_hit) begin
              duty_d  = max_eff_q;
              hold_d  = hold_eff_q;
              state_d = StHoldHigh;
            end else begin
              duty_d = sum_up[15:0];
            end
          end
        end
        StHoldHigh: begin
          if (tick_q) begin
            if (hold_q == 16'd0) begin
              state_d = StRampDown;
            end else begin
              hold_d = hold_q - 16'd1;
            end
          end
        end
        StRampDown: begin
          if (tick_q) begin
            if (dn_hit) begin
              duty_d  = min_eff_q;
              hold_d  = hold_eff_q;
              state_d = StHoldLow;
            end else begin
              // dn_hit false guarantees duty > min+step, so no underflow.
              duty_d = duty_q - step_eff_q;
            end
          end
        end
        StHoldLow: begin
          if (tick_q) begin
            if (hold_q == 16'd0) begin
              done_d  = 1'b1;
              sample  = 1'b1;
              duty_d  = cfg_min;
              state_d = StRampUp;
            end else begin
              hold_d = hold_q - 16'd1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          duty_d  = 16'd0;
          hold_d  = 16'd0;
        end
      endcase
    end

    if (sample) begin
      max_eff_d  = cfg_max;
      min_eff_d  = cfg_min;
      step_eff_d = cfg_step;
      hold_eff_d = hold_cycles;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= 16'd0;
      tick_q     <= 1'b0;
      state_q    <= StIdle;
      duty_q     <= 16'd0;
      hold_q     <= 16'd0;
      done_q     <= 1'b0;
      max_eff_q  <= 16'd0;
      min_eff_q  <= 16'd0;
      step_eff_q <= 16'd0;
      hold_eff_q <= 16'd0;
    end else begin
      pcnt_q     <= pcnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      duty_q     <= duty_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      max_eff_q  <= max_eff_d;
      min_eff_q  <= min_eff_d;
      step_eff_q <= step_eff_d;
      hold_eff_q <= hold_eff_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign period      = PeriodW;
  assign update_tick = tick_q;
  assign state       = state_q;
  assign cycle_done  = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer with PERIOD=10. A period-level profile model predicts every
// output on every clock; directed phases add literal expectations for the same behaviour.
`timescale 1ns/1ps
module tb_pwm_fade_sequencer;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned PWM_FREQ = 100;
  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] min_duty = 16'd0;
  logic [15:0] max_duty = 16'd0;
  logic [15:0] step = 16'd0;
  logic [15:0] hold_cycles = 16'd0;
  logic [15:0] duty_cycle;
  logic [15:0] period;
  logic        update_tick;
  logic [2:0]  state;
  logic        cycle_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pwm_fade_sequencer #(
    .CLK_FREQ(CLK_FREQ),
    .PWM_FREQ(PWM_FREQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .min_duty   (min_duty),
    .max_duty   (max_duty),
    .step       (step),
    .hold_cycles(hold_cycles),
    .duty_cycle (duty_cycle),
    .period     (period),
    .update_tick(update_tick),
    .state      (state),
    .cycle_done (cycle_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one fade cycle as a list of per-period (duty, state) ------------
  int prof_d[64];
  int prof_s[64];
  int plen = 0;
  bit m_run = 1'b0;
  int m_pc = 0;
  int m_idx = 0;
  bit m_done = 1'b0;

  task automatic add_period(input int d, input int s);
    if (plen < 64) begin
      prof_d[plen] = d;
      prof_s[plen] = s;
      plen++;
    end
  endtask

  task automatic build_profile();
    int mx, mn, st, hd, d;
    mx = (int'(max_duty) < PERIOD) ? int'(max_duty) : PERIOD;
    mn = (int'(min_duty) < mx) ? int'(min_duty) : mx;
    st = (step == 16'd0) ? 1 : int'(step);
    hd = int'(hold_cycles);
    plen = 0;
    d = mn;
    while (1) begin
      add_period(d, 1);
      if (d + st >= mx) break;
      d += st;
    end
    for (int i = 0; i <= hd; i++) add_period(mx, 2);
    d = mx;
    while (1) begin
      add_period(d, 3);
      if (d <= mn + st) break;
      d -= st;
    end
    for (int i = 0; i <= hd; i++) add_period(mn, 4);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0; m_pc = 0; m_idx = 0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (!enable) begin
          m_run = 1'b0; m_pc = 0; m_idx = 0;
        end else if (!m_run) begin
          build_profile();
          m_run = 1'b1; m_pc = 0; m_idx = 0;
        end else begin
          m_pc++;
          if (m_pc == PERIOD) begin
            m_pc = 0;
            m_idx++;
            if (m_idx >= plen) begin
              m_done = 1'b1;
              build_profile();
              m_idx = 0;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("duty", int'(duty_cycle), m_run ? prof_d[m_idx] : 0);
      chk("state", int'(state), m_run ? prof_s[m_idx] : 0);
      chk("tick", int'(update_tick), (m_run && m_pc == PERIOD - 1) ? 1 : 0);
      chk("done", int'(cycle_done), int'(m_done));
      chk("period", int'(period), PERIOD);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  int exp2_d[9] = '{2, 5, 8, 8, 8, 5, 2, 2, 2};
  int exp2_s[9] = '{1, 1, 2, 2, 3, 3, 4, 4, 1};
  int exp2_c[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  int t3_d[23];
  int t3_s[23];
  int t3_c[23];

  task automatic wait_tick(output int d, output int s, output int n, output int dn);
    d = 0; s = 0; n = 0; dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (cycle_done) dn++;
      if (update_tick) begin
        d = int'(duty_cycle);
        s = int'(state);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL tick_timeout: got no tick, want one within 40 clocks (t=%0t)", $time);
  endtask

  task automatic restart(input int mn, input int mx, input int st, input int hd);
    enable = 1'b0;
    @(negedge clk);
    min_duty = 16'(mn); max_duty = 16'(mx); step = 16'(st); hold_cycles = 16'(hd);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int d, s, n, dn, ticks_seen;
    bit found;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    chk("t1_rst_duty", int'(duty_cycle), 0);
    chk("t1_rst_done", int'(cycle_done), 0);
    rst_n = 1'b1;
    ticks_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (update_tick) ticks_seen++;
    end
    chk("t1_no_ticks", ticks_seen, 0);
    chk("t1_state", int'(state), 0);
    chk("t1_period", int'(period), 10);

    // 2: basic trapezoid, with a mid-cycle limit change that must be ignored
    min_duty = 16'd2; max_duty = 16'd8; step = 16'd3; hold_cycles = 16'd1;
    enable = 1'b1;
    @(negedge clk);
    chk("t2_start_duty", int'(duty_cycle), 2);
    chk("t2_start_state", int'(state), 1);
    for (int i = 0; i < 9; i++) begin
      wait_tick(d, s, n, dn);
      chk($sformatf("t2_duty%0d", i), d, exp2_d[i]);
      chk($sformatf("t2_state%0d", i), s, exp2_s[i]);
      chk($sformatf("t2_done%0d", i), dn, exp2_c[i]);
      chk($sformatf("t2_gap%0d", i), n, (i == 0) ? 9 : 10);
      if (i == 0) max_duty = 16'd6;
      if (i == 2) max_duty = 16'd8;
    end

    // 5: drop enable on the RAMP_DOWN tick at duty 5 (tick and disable collide)
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      wait_tick(d, s, n, dn);
      if (s == 3 && d == 5) found = 1'b1;
    end
    chk("t5_found_rampdown5", int'(found), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_idle_state", int'(state), 0);
    chk("t5_idle_duty", int'(duty_cycle), 0);
    chk("t5_idle_done", int'(cycle_done), 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_re_duty", int'(duty_cycle), 2);
    chk("t5_re_state", int'(state), 1);
    wait_tick(d, s, n, dn);
    chk("t5_re_gap", n, 9);

    // 3: clamp max to PERIOD, zero step treated as one
    restart(0, 50, 0, 0);
    chk("t3_start_duty", int'(duty_cycle), 0);
    for (int i = 0; i < 23; i++) begin
      wait_tick(d, s, n, dn);
      t3_d[i] = d; t3_s[i] = s; t3_c[i] = dn;
    end
    chk("t3_d9", t3_d[9], 9);
    chk("t3_d10", t3_d[10], 10);
    chk("t3_s10", t3_s[10], 2);
    chk("t3_d11", t3_d[11], 10);
    chk("t3_s11", t3_s[11], 3);
    chk("t3_d20", t3_d[20], 1);
    chk("t3_d21", t3_d[21], 0);
    chk("t3_s21", t3_s[21], 4);
    chk("t3_s22", t3_s[22], 1);
    chk("t3_c22", t3_c[22], 1);

    // 4: min above max collapses to a flat profile, one tick per state
    restart(9, 4, 1, 0);
    chk("t4_start_duty", int'(duty_cycle), 4);
    for (int i = 0; i < 9; i++) begin
      wait_tick(d, s, n, dn);
      chk($sformatf("t4_duty%0d", i), d, 4);
      chk($sformatf("t4_state%0d", i), s, (i % 4) + 1);
      chk($sformatf("t4_done%0d", i), dn, (i == 4 || i == 8) ? 1 : 0);
    end

    // 6: asynchronous reset in HOLD_HIGH
    restart(2, 8, 3, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      wait_tick(d, s, n, dn);
      if (s == 2) found = 1'b1;
    end
    chk("t6_found_hold_high", int'(found), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_duty", int'(duty_cycle), 0);
    chk("t6_async_state", int'(state), 0);
    chk("t6_async_tick", int'(update_tick), 0);
    chk("t6_async_done", int'(cycle_done), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rel_state", int'(state), 0);
    @(negedge clk);
    chk("t6_restart_duty", int'(duty_cycle), 2);
    chk("t6_restart_state", int'(state), 1);
    wait_tick(d, s, n, dn);
    chk("t6_gap", n, 9);
    wait_tick(d, s, n, dn);
    chk("t6_second_duty", d, 5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Upstream stage of the PWM core. Generates the duty_cycle/period pair that the core consumes.
- Repeats a trapezoidal brightness profile: ramp up, hold high, ramp down, hold low.
- Duty updates happen exactly once per PWM period, at the period boundary, so the core never sees a mid-period change.
- All fade limits are run-time inputs, sampled once per fade cycle.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- PWM_FREQ, 500, PWM frequency in Hz.
- PERIOD, CLK_FREQ/PWM_FREQ (localparam, must be in 2..65535), PWM period in clocks.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run the fade sequence; low forces IDLE.
- min_duty  input  16  lower duty limit, in clocks.
- max_duty  input  16  upper duty limit, in clocks.
- step  input  16  duty increment/decrement per PWM period.
- hold_cycles  input  16  extra PWM periods spent at each end.
- duty_cycle  output  16  duty to PWM core, registered.
- period  output  16  constant PERIOD to PWM core.
- update_tick  output  1  one-clock pulse at the last clock of each PWM period.
- state  output  3  FSM state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- cycle_done  output  1  one-clock pulse when HOLD_LOW exits.

Behaviour:
- Reset (async, rst_n low) values:
  - duty_cycle=0, state=IDLE, update_tick=0, cycle_done=0.
  - Period counter pcnt=0, hold counter=0.
  - period always equals PERIOD.
- Period counter:
  - pcnt runs 0..PERIOD-1 and wraps to 0.
  - update_tick is registered and high during the clock where pcnt==PERIOD-1.
  - When enable is low, pcnt is held at 0.
- Config sampling happens on IDLE->RAMP_UP and on HOLD_LOW->RAMP_UP. Latched values:
  - max_eff = min(max_duty, PERIOD).
  - min_eff = min(min_duty, max_eff).
  - step_eff = (step==0) ? 1 : step.
  - hold_eff = hold_cycles.
- Arithmetic is 17-bit and never wraps: duty+step saturates to max_eff; duty-step saturates to min_eff.
- Every FSM transition below except IDLE->RAMP_UP fires only on a clock where update_tick=1. The new duty_cycle is visible from pcnt==0 of the next period.
- FSM transitions:
  - IDLE:
    - duty_cycle=0.
    - When enable=1: sample config, set duty_cycle<=min_eff, clear pcnt, go to RAMP_UP on the next clock.
  - RAMP_UP, on tick:
    - If duty+step_eff >= max_eff: duty<=max_eff, load hold counter with hold_eff, go to HOLD_HIGH.
    - Else: duty<=duty+step_eff.
  - HOLD_HIGH, on tick:
    - If hold counter==0: go to RAMP_DOWN.
    - Else: decrement hold counter.
    - Total time spent in HOLD_HIGH is hold_eff+1 ticks.
  - RAMP_DOWN, on tick:
    - If duty <= min_eff+step_eff: duty<=min_eff, load hold counter, go to HOLD_LOW.
    - Else: duty<=duty-step_eff.
  - HOLD_LOW, on tick:
    - Same hold rule as HOLD_HIGH.
    - On exit: cycle_done=1 for one clock, resample config, duty<=new min_eff, go to RAMP_UP.
- Boundary cases:
  - min_eff==max_eff: each ramp lasts one tick, and duty stays constant.
  - Changes to the limit inputs mid-cycle are ignored until the next sample point.
- enable low in any non-IDLE state:
  - On the next clock: state=IDLE, duty_cycle=0, pcnt=0, hold counter=0.
  - No cycle_done pulse.
  - This takes priority over a simultaneous tick.
- Reset mid-operation: outputs return to reset values immediately (async). Operation resumes from IDLE after rst_n rises.

Test Plan (use CLK_FREQ=1000, PWM_FREQ=100, so PERIOD=10):
1. Reset, enable=0 -> duty_cycle=0, state=0, period=10, update_tick never pulses, cycle_done=0.
2. min=2, max=8, step=3, hold=1, enable=1 -> duty sequence per tick: 2,5,8; HOLD_HIGH for 2 ticks; then 5,2; HOLD_LOW for 2 ticks; then one cycle_done pulse and return to RAMP_UP at 2. Ticks spaced exactly 10 clocks apart, and duty changes only at pcnt==0.
3. min=0, max=50, step=0, hold=0 -> max clamped to 10 and step treated as 1. Duty goes 0,1,...,10, holds 1 tick, then 9,...,0. No counter wrap or overflow.
4. min=9, max=4 -> min_eff=4 and duty_cycle stays at 4 for the whole fade cycle. cycle_done pulses every 4 ticks (one tick in each of the four states).
5. enable dropped during RAMP_DOWN at duty=5 -> next clock: state=0, duty_cycle=0. Re-enabling restarts at min_eff with pcnt=0.
6. rst_n pulsed low mid HOLD_HIGH, asynchronously between clock edges -> outputs go to 0 immediately. After release with enable=1, the sequence restarts from min_eff.
